link_tx_hs4: RTL and testbench

- Parametrised successor to the byte-wide master of the req/ack link.
- Accepts words from a local producer via valid/ready into an internal FIFO.
- Drains each word over a 4-phase req/ack handshake to a slave that may sit in another clock domain (ack is synchronised).
- Adds buffering, generic data width, ack-timeout detection with bounded retry, and transfer/drop accounting.

---
 rtl/link_pkg.sv | 21 ++
 rtl/link_fifo.sv | 71 +++++++
 rtl/link_tx_hs4.sv | 189 ++++++++++++++++++
 tb/tb_link_tx_hs4.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the req/ack link transmitter.
// Holds the handshake FSM state type, default widths and a helper that sizes
// occupancy counters.
package link_pkg;

  localparam int unsigned LINK_DW   = 8;
  localparam int unsigned LINK_SYNC = 2;

  typedef enum logic [1:0] {
    StIdle,
    StReqHi,
    StReqLo,
    StAbort
  } link_state_e;

  // Bits needed to hold a count from 0 to depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/link_fifo.sv
// Word FIFO buffering producer data ahead of the req/ack handshake.
// Ports:
//   clk, rst   clock and synchronous active-low reset
//   push, wdata  write request and word (ignored while full)
//   pop        remove head word (ignored while empty)
//   head       word at the read pointer, valid while not empty
//   level      occupancy, 0..DEPTH
//   full, empty  occupancy flags
module link_fifo
  import link_pkg::*;
#(
  parameter int unsigned DW    = LINK_DW,
  parameter int unsigned DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [DW-1:0]                   wdata,
  input  logic                            pop,
  output logic [DW-1:0]                   head,
  output logic [level_width(DEPTH)-1:0]   level,
  output logic                            full,
  output logic                            empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [LW-1:0] level_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rptr_q];
  assign level   = level_q;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        level_q <= level_q + LW'(1);
      end else if (do_pop && !do_push) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

  // Storage needs no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/link_tx_hs4.sv
// Buffered 4-phase req/ack link master.
// Words from a valid/ready producer are queued in a FIFO and sent one at a
// time over req/ack to a slave that may live in another clock domain. A wait
// phase that runs too long flags err_timeout; a word whose request times out
// is retried up to MAX_RETRY times and then discarded with a drop pulse.
// Ports:
//   clk, rst            clock and synchronous active-low reset
//   in_valid/in_ready/in_data  producer interface
//   req, data           handshake request and word to the slave
//   ack                 slave acknowledge (asynchronous, synchronised here)
//   busy                FIFO non-empty or handshake in progress
//   level               FIFO occupancy
//   sent_cnt            completed transfers, wrapping
//   drop                one-cycle pulse when a word is discarded
//   err_timeout         sticky timeout flag
module link_tx_hs4
  import link_pkg::*;
#(
  parameter int unsigned DW          = LINK_DW,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = LINK_SYNC,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DW-1:0]                 in_data,
  output logic                          req,
  output logic [DW-1:0]                 data,
  input  logic                          ack,
  output logic                          busy,
  output logic [level_width(DEPTH)-1:0] level,
  output logic [15:0]                   sent_cnt,
  output logic                          drop,
  output logic                          err_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  link_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          req_q, req_d;
  logic [DW-1:0] data_q, data_d;
  logic [15:0]   sent_q, sent_d;
  logic          err_q, err_d;
  logic          drop_q, drop_d;

  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  logic                   timed_out;

  logic          fifo_push;
  logic          fifo_pop;
  logic [DW-1:0] fifo_head;
  logic          fifo_full;
  logic          fifo_empty;

  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & in_ready;

  link_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (in_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ack_s     = ack_sync_q[SYNC_STAGES-1];
  assign timed_out = (timer_q == TIMER_MAX);

  // State register, including the ack synchroniser chain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_sync_q <= '0;
      state_q    <= StIdle;
      timer_q    <= '0;
      retry_q    <= '0;
      req_q      <= 1'b0;
      data_q     <= '0;
      sent_q     <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      ack_sync_q <= (ack_sync_q << 1) | SYNC_STAGES'(ack);
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      req_q      <= req_d;
      data_q     <= data_d;
      sent_q     <= sent_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state and registered-output updates.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    req_d   = req_q;
    data_d  = data_q;
    sent_d  = sent_q;
    err_d   = err_q;
    drop_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Never raise req while the previous ack is still visible.
        if (!fifo_empty && !ack_s) begin
          data_d  = fifo_head;
          req_d   = 1'b1;
          state_d = StReqHi;
        end
      end
      StReqHi: begin
        if (ack_s) begin
          req_d   = 1'b0;
          sent_d  = sent_q + 16'd1;
          retry_d = '0;
          state_d = StReqLo;
        end else if (timed_out) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = StAbort;
        end
      end
      StReqLo: begin
        if (!ack_s) begin
          state_d = StIdle;
        end else if (timed_out) begin
          // Word already counted; IDLE keeps req low until ack_s clears.
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StAbort: begin
        if (!ack_s) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
          end else begin
            drop_d  = 1'b1;
            retry_d = '0;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Timer restarts on every state change and saturates otherwise.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timed_out) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Combinational outputs.
  always_comb begin
    fifo_pop = 1'b0;
    unique case (state_q)
      StReqHi: fifo_pop = ack_s;
      StAbort: fifo_pop = !ack_s && (retry_q >= RETRY_MAX);
      default: fifo_pop = 1'b0;
    endcase
  end

  assign busy        = !fifo_empty || (state_q != StIdle);
  assign req         = req_q;
  assign data        = data_q;
  assign sent_cnt    = sent_q;
  assign drop        = drop_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_link_tx_hs4.sv
// Self-checking bench for link_tx_hs4 (DW=8, DEPTH=4, TIMEOUT=8, MAX_RETRY=2).
// A slave model answers req with a configurable behaviour and logs every word
// it accepts; expected words, counts and pulse shapes come from the bench.
module tb_link_tx_hs4;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned TMO   = 8;
  localparam int unsigned MAXR  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        req;
  logic [7:0]  data;
  logic        ack = 1'b0;
  logic        busy;
  logic [2:0]  level;
  logic [15:0] sent_cnt;
  logic        drop;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  link_tx_hs4 #(
    .DW          (DW),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC),
    .TIMEOUT     (TMO),
    .MAX_RETRY   (MAXR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .req         (req),
    .data        (data),
    .ack         (ack),
    .busy        (busy),
    .level       (level),
    .sent_cnt    (sent_cnt),
    .drop        (drop),
    .err_timeout (err_timeout)
  );

  // Slave: 0 fixed delay, 1 silent, 2 silent on first attempt, 3 random delay.
  int         slave_mode = 0;
  int         slave_delay = 3;
  int         attempt_base = 0;
  int         attempts = 0;
  int         scnt = 0;
  int         cur_delay = 3;
  logic       sreq_prev = 1'b0;
  logic [7:0] rx_mem [0:1023];
  int         rx_n = 0;

  always @(negedge clk) begin
    if (req && !sreq_prev) begin
      attempts = attempts + 1;
      scnt = 0;
      cur_delay = (slave_mode == 3) ? int'($urandom_range(4, 1)) : slave_delay;
    end
    sreq_prev = req;
    if (req && !ack) begin
      if (!(slave_mode == 1 || (slave_mode == 2 && attempts - attempt_base == 1))) begin
        scnt = scnt + 1;
        if (scnt >= cur_delay) begin
          ack = 1'b1;
          if (rx_n < 1024) rx_mem[rx_n] = data;
          rx_n = rx_n + 1;
        end
      end
    end else if (!req && ack) begin
      ack = 1'b0;
    end
  end

  // Monitor: req pulse lengths, drop width, data stability while req is high.
  int         rise_n = 0;
  int         fall_n = 0;
  int         run = 0;
  int         drop_cycles = 0;
  int         glitch_n = 0;
  int         pulse_len [0:255];
  logic       mreq_prev = 1'b0;
  logic [7:0] mdata_prev = 8'h00;

  always @(negedge clk) begin
    if (req && !mreq_prev) rise_n = rise_n + 1;
    if (req) begin
      run = run + 1;
    end else if (mreq_prev) begin
      if (fall_n < 256) pulse_len[fall_n] = run;
      fall_n = fall_n + 1;
      run = 0;
    end
    if (req && mreq_prev && data !== mdata_prev) glitch_n = glitch_n + 1;
    if (drop === 1'b1) drop_cycles = drop_cycles + 1;
    mreq_prev = req;
    mdata_prev = data;
  end

  logic [7:0] exp_q [$];
  int         rx_base = 0;
  int         exp_sent = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy && !req && !ack) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    tick();
  endtask

  // Presents a word and returns at the negedge after it was accepted.
  task automatic push_word(input logic [7:0] w, input int budget, output bit ok);
    in_valid = 1'b1;
    in_data = w;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_rx_count"}, rx_n - rx_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rx_base + i < 1024) check({tag, "_rx_word"}, rx_mem[rx_base + i], exp_q[i]);
    end
    rx_base = rx_n;
    exp_q.delete();
  endtask

  initial begin
    bit         ok;
    bit         all_ok;
    bit         seen;
    int         f0;
    int         d0;
    int         r0;
    int         gap;
    logic [7:0] w;
    logic [2:0] lb;
    logic       rb;

    rst = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check("rst_req", req, 0);
    check("rst_data", data, 0);
    check("rst_sent", sent_cnt, 0);
    check("rst_err", err_timeout, 0);
    check("rst_drop", drop, 0);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b1;
    tick();

    // Single word, slave acks 3 cycles after req.
    slave_mode = 0;
    slave_delay = 3;
    in_valid = 1'b1;
    in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    check("t1_level_after_push", level, 1);
    check("t1_req_not_yet", req, 0);
    tick();
    check("t1_req_high", req, 1);
    check("t1_data", data, 8'hA5);
    exp_q.push_back(8'hA5);
    exp_sent = exp_sent + 1;
    wait_idle(100, ok);
    check("t1_idle", ok, 1);
    check("t1_sent", sent_cnt, exp_sent);
    check("t1_level_end", level, 0);
    check("t1_busy_end", busy, 0);
    check_rx("t1");

    // Six words back to back against a slow slave.
    slave_delay = 5;
    all_ok = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      push_word(8'(i), 200, ok);
      all_ok = all_ok & ok;
      exp_q.push_back(8'(i));
      if (i == 4) begin
        check("t2_full_level", level, 4);
        check("t2_full_ready", in_ready, 0);
      end
    end
    in_valid = 1'b0;
    check("t2_push", all_ok, 1);
    exp_sent = exp_sent + 6;
    wait_idle(400, ok);
    check("t2_idle", ok, 1);
    check("t2_sent", sent_cnt, exp_sent);
    check_rx("t2");

    // Random words, gaps and slave delays; order and count must hold.
    slave_mode = 3;
    all_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      gap = int'($urandom_range(3, 0));
      in_valid = 1'b0;
      repeat (gap) tick();
      w = 8'($urandom);
      push_word(w, 200, ok);
      all_ok = all_ok & ok;
      exp_q.push_back(w);
    end
    in_valid = 1'b0;
    check("rand_push", all_ok, 1);
    exp_sent = exp_sent + 40;
    wait_idle(2000, ok);
    check("rand_idle", ok, 1);
    check("rand_sent", sent_cnt, exp_sent);
    check("rand_err", err_timeout, 0);
    check("rand_drop", drop_cycles, 0);
    check_rx("rand");

    // First attempt times out, retry succeeds.
    slave_mode = 2;
    slave_delay = 3;
    attempt_base = attempts;
    f0 = fall_n;
    d0 = drop_cycles;
    in_valid = 1'b1;
    in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(8'h3C);
    exp_sent = exp_sent + 1;
    wait_idle(300, ok);
    check("t4_idle", ok, 1);
    check("t4_pulses", fall_n - f0, 2);
    check("t4_first_pulse_len", pulse_len[f0], TMO);
    check("t4_err", err_timeout, 1);
    check("t4_sent", sent_cnt, exp_sent);
    check("t4_no_drop", drop_cycles - d0, 0);
    check_rx("t4");

    // Slave never answers: three attempts, then one drop.
    slave_mode = 1;
    f0 = fall_n;
    d0 = drop_cycles;
    in_valid = 1'b1;
    in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    check("t5_level_start", level, 1);
    wait_idle(500, ok);
    check("t5_idle", ok, 1);
    check("t5_pulses", fall_n - f0, 3);
    for (int i = 0; i < 3; i++) check("t5_pulse_len", pulse_len[f0 + i], TMO);
    check("t5_drop_cycles", drop_cycles - d0, 1);
    check("t5_level_end", level, 0);
    check("t5_sent", sent_cnt, exp_sent);
    check_rx("t5");

    // Reset while a request is outstanding and three words are queued.
    slave_mode = 1;
    for (int i = 0; i < 3; i++) begin
      push_word(8'hC0 + 8'(i), 50, ok);
    end
    in_valid = 1'b0;
    check("t6_pre_req", req, 1);
    check("t6_pre_level", level, 3);
    rst = 1'b0;
    tick();
    check("t6_req", req, 0);
    check("t6_level", level, 0);
    check("t6_sent", sent_cnt, 0);
    check("t6_err", err_timeout, 0);
    check("t6_busy", busy, 0);
    rst = 1'b1;
    slave_mode = 0;
    exp_sent = 0;
    r0 = rise_n;
    repeat (20) tick();
    check("t6_no_spurious_req", rise_n - r0, 0);
    rx_base = rx_n;
    exp_q.delete();

    // Push attempted at full in the cycle a handshake pops the head.
    slave_mode = 0;
    slave_delay = 3;
    for (int i = 0; i < 4; i++) begin
      push_word(8'h50 + 8'(i), 50, ok);
      exp_q.push_back(8'h50 + 8'(i));
    end
    in_valid = 1'b1;
    in_data = 8'h54;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      lb = level;
      rb = in_ready;
      tick();
      if (lb == 3'd4 && level != 3'd4) begin
        check("t7_ready_at_full", rb, 0);
        check("t7_level_after_pop", level, DEPTH - 1);
        seen = 1'b1;
        break;
      end
    end
    check("t7_pop_at_full_seen", seen, 1);
    push_word(8'h54, 50, ok);
    in_valid = 1'b0;
    check("t7_push_late", ok, 1);
    exp_q.push_back(8'h54);
    exp_sent = exp_sent + 5;
    wait_idle(400, ok);
    check("t7_idle", ok, 1);
    check("t7_sent", sent_cnt, exp_sent);
    check_rx("t7");

    check("data_stable_during_req", glitch_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
